uart_fifo_tx: RTL and testbench

Serial transmitter that drains the read port of an `MFifo` instance and shifts each word out as an asynchronous UART-style frame on a single line. Sits on the FIFO's read-clock domain: it pulls words with `r_en`, consumes `r_data`, and honours `empty`. It is the consuming end for data written into the FIFO by the producer.

---
 rtl/uart_fifo_tx.sv | 130 +++++++++++++
 tb/tb_uart_fifo_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// UART-style frame transmitter that drains the read port of an MFifo, one word per frame.
// state  | meaning
// IDLE   | waiting for a word; r_en = !empty
// FETCH  | r_data valid, load shift register, clear parity
// START  | start bit, tx low
// DATA   | P_WIDTH data bits, LSB first
// PARITY | optional parity bit
// STOP   | P_STOP_BITS stop bits, tx high
module uart_fifo_tx #(
    parameter int P_WIDTH        = 8,
    parameter int P_CLKS_PER_BIT = 16,
    parameter int P_PARITY       = 0,
    parameter int P_STOP_BITS    = 1
) (
    input  logic               r_clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [P_WIDTH-1:0] r_data,
    output logic               r_en,
    output logic               tx,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(P_CLKS_PER_BIT);
    localparam int IW = $clog2(P_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(P_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(P_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [P_WIDTH-1:0] shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_d;
    logic               bit_end;

    assign bit_end = (count_q == CNT_LAST);

    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx      <= tx_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_q == S_STOP) && (state_d == S_IDLE);
        end
    end

    // idx counts data bits in DATA and is reused to count stop bits in STOP
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_FETCH;
            end
            S_FETCH: begin
                shift_d = r_data;
                par_d   = 1'b0;
                idx_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (P_PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) state_d = S_IDLE;
                    else                    idx_d   = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE || state_q == S_FETCH || state_d != state_q || bit_end)
            count_d = '0;
        else
            count_d = count_q + CW'(1);
    end

    // tx is driven from the next-state view so the registered line lines up with state entry
    always_comb begin
        r_en = (state_q == S_IDLE) && !empty;
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d ^ (P_PARITY == 2);
            default:  tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: four instances at 4 clocks/bit (plain, even parity, odd parity,
// two stop bits) fed from a FIFO model; a per-instance monitor decodes tx against expected frames.
module tb_uart_fifo_tx;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] empty_v = 4'hF;
    logic [3:0] r_en_v, tx_v, busy_v, done_v;
    logic [7:0] r_data_a [4];

    logic [7:0]  fq    [4][$];
    logic [11:0] exp_q [4][$];
    int          st_q  [4][$];
    int          rd_cnt   [4];
    int          done_cnt [4];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NB = 1 + 8 + ((par_of(g) != 0) ? 1 : 0) + stop_of(g);
        localparam int L  = NB * C;

        uart_fifo_tx #(
            .P_WIDTH(8),
            .P_CLKS_PER_BIT(C),
            .P_PARITY(par_of(g)),
            .P_STOP_BITS(stop_of(g))
        ) dut (
            .r_clk(clk),
            .rst(rst),
            .empty(empty_v[g]),
            .r_data(r_data_a[g]),
            .r_en(r_en_v[g]),
            .tx(tx_v[g]),
            .busy(busy_v[g]),
            .done(done_v[g])
        );

        int          ph = -1;
        logic [11:0] fr;
        logic [11:0] ew;

        // ph counts negedges since tx fell; each bit is sampled one cycle into its bit time
        always @(negedge clk) begin
            if (rst) begin
                if (ph >= 0 && exp_q[g].size() > 0) ew = exp_q[g].pop_front();
                ph = -1;
            end else begin
                if (ph >= 0) ph++;
                else if (!tx_v[g]) begin
                    ph = 0;
                    st_q[g].push_back(cyc);
                end
                if (ph == 1) check("busy_frame", busy_v[g], 1);
                if (ph >= 0 && ph < L && ph % C == 1) fr = {tx_v[g], fr[11:1]};
                if (ph == L - 1) check("done_early", done_v[g], 0);
                if (ph == L) begin
                    check("done_pulse", done_v[g], 1);
                    check("busy_end", busy_v[g], 0);
                    check("exp_pending", exp_q[g].size() > 0, 1);
                    if (exp_q[g].size() > 0) begin
                        ew = exp_q[g].pop_front();
                        check("frame", fr >> (12 - NB), ew);
                    end
                end
                if (ph == L + 1) begin
                    check("done_width", done_v[g], 0);
                    ph = -1;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (r_en_v[i] && fq[i].size() > 0) r_data_a[i] <= fq[i].pop_front();
            empty_v[i] <= (fq[i].size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (r_en_v[i]) begin
                    rd_cnt[i]++;
                    check("read_when_empty", empty_v[i], 0);
                end
                if (done_v[i]) done_cnt[i]++;
            end
        end
    end

    task automatic push(input int i, input logic [7:0] d, input logic [11:0] frame);
        fq[i].push_back(d);
        exp_q[i].push_back(frame);
    endtask

    task automatic wait_done(input int i, input int n, input int budget);
        int k;
        k = 0;
        while (done_cnt[i] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check("done_count", done_cnt[i], n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // idle with empty FIFOs
        repeat (200) begin
            @(negedge clk);
            check("idle", {tx_v, r_en_v, busy_v, done_v}, 16'hF000);
        end

        // single frame 0x55, frames are {stop.., parity?, data, start} LSB first
        push(0, 8'h55, 12'h2AA);
        wait_done(0, 1, 200);
        check("rd_single", rd_cnt[0], 1);

        // even parity, odd parity, two stop bits in parallel
        push(1, 8'h07, 12'h60E);
        push(2, 8'h07, 12'h40E);
        push(3, 8'hA3, 12'h746);
        wait_done(1, 1, 200);
        wait_done(2, 1, 200);
        wait_done(3, 1, 200);
        check("rd_par_even", rd_cnt[1], 1);
        check("rd_par_odd", rd_cnt[2], 1);
        check("rd_stop2", rd_cnt[3], 1);

        // back-to-back frames
        st_q[0].delete();
        push(0, 8'h01, 12'h202);
        push(0, 8'h80, 12'h300);
        push(0, 8'hFF, 12'h3FE);
        wait_done(0, 4, 400);
        check("b2b_starts", st_q[0].size(), 3);
        if (st_q[0].size() == 3) begin
            check("b2b_gap01", st_q[0][1] - st_q[0][0], 10 * C + 2);
            check("b2b_gap12", st_q[0][2] - st_q[0][1], 10 * C + 2);
        end
        check("rd_b2b", rd_cnt[0], 4);
        repeat (100) @(negedge clk);
        check("no_extra_read", rd_cnt[0], 4);
        check("fifo_drained", empty_v[0], 1);

        // reset during data bit 3 of 0x3C, then 0x12 must follow
        push(0, 8'h3C, 12'h278);
        k = 0;
        while (tx_v[0] !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", tx_v[0], 0);
        repeat (4 * C + 1) @(negedge clk);
        check("busy_before_rst", busy_v[0], 1);
        #1 rst = 1'b1;
        #1;
        check("rst_tx", tx_v[0], 1);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        push(0, 8'h12, 12'h224);
        wait_done(0, 5, 200);
        check("rd_total", rd_cnt[0], 6);
        check("exp_drained", exp_q[0].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
